// File: rtl/enoc_traffic_harness.sv
// LFSR traffic generator and signature sink for ENoC bring-up: drives every node input and folds
// every delivery into a running signature so the mesh survives synthesis and is checkable from pins.

module enoc_traffic_harness #(
    parameter int unsigned NODES         = 16,
    parameter int unsigned DATA_W        = 32,
    parameter logic [31:0] LFSR_SEED     = 32'hACE1_0001,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned DRAIN_TIMEOUT = 1024
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           i_start,
    input  logic [7:0]                     i_rate,
    input  logic [CNT_W-1:0]               i_num_pkts,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_timeout,
    output logic [CNT_W+$clog2(NODES)-1:0] o_tx_count,
    output logic [CNT_W+$clog2(NODES)-1:0] o_rx_count,
    output logic [DATA_W-1:0]              o_signature,
    output logic [NODES*DATA_W-1:0]        o_net_data,
    output logic [NODES-1:0]               o_net_data_val,
    input  logic [NODES-1:0]               i_net_en,
    input  logic [NODES*DATA_W-1:0]        i_net_data,
    input  logic [NODES-1:0]               i_net_data_val,
    output logic [NODES-1:0]               o_net_en
);

    localparam int unsigned TW  = CNT_W + $clog2(NODES);
    localparam int unsigned DCW = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    function automatic logic [7:0] rate_seed(input int unsigned k);
        return 8'((k % 255) + 1);
    endfunction

    function automatic logic [31:0] data_seed(input int unsigned k);
        logic [31:0] s;
        s = LFSR_SEED ^ 32'(k);
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

    // Galois, right-shifting: x^8+x^6+x^5+x^4+1
    function automatic logic [7:0] rate_step(input logic [7:0] r);
        return r[0] ? ((r >> 1) ^ 8'hB8) : (r >> 1);
    endfunction

    // Galois, right-shifting: x^32+x^22+x^2+x+1
    function automatic logic [31:0] data_step(input logic [31:0] r);
        return r[0] ? ((r >> 1) ^ 32'h8020_0003) : (r >> 1);
    endfunction

    function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x, input int unsigned s);
        logic [2*DATA_W-1:0] xx;
        xx = {x, x} >> (DATA_W - s);
        return xx[DATA_W-1:0];
    endfunction

    function automatic logic [TW-1:0] popcnt(input logic [NODES-1:0] v);
        logic [TW-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < NODES; i++) c = c + TW'(v[i]);
        return c;
    endfunction

    state_e              state_q, state_d;
    logic                start_q;
    logic [7:0]          rate_cfg_q, rate_cfg_d;
    logic [CNT_W-1:0]    budget_q, budget_d;
    logic [7:0]          rate_lfsr_q [NODES];
    logic [7:0]          rate_lfsr_d [NODES];
    logic [31:0]         data_lfsr_q [NODES];
    logic [31:0]         data_lfsr_d [NODES];
    logic [CNT_W-1:0]    loaded_q [NODES];
    logic [CNT_W-1:0]    loaded_d [NODES];
    logic [DATA_W-1:0]   data_q [NODES];
    logic [DATA_W-1:0]   data_d [NODES];
    logic [NODES-1:0]    val_q, val_d;
    logic [TW-1:0]       tx_q, tx_d, rx_q, rx_d;
    logic [DATA_W-1:0]   sig_q, sig_d;
    logic                timeout_q, timeout_d;
    logic [DCW-1:0]      drain_q, drain_d;

    logic                busy, start_rise, all_sent;
    logic [NODES-1:0]    net_en, dlv, acc, xfer;
    logic [7:0]          rate_nxt [NODES];
    logic [31:0]         data_nxt [NODES];
    logic [DATA_W-1:0]   in_data [NODES];
    logic [DATA_W-1:0]   fold_term [NODES];
    logic [DATA_W-1:0]   fold;

    assign busy       = (state_q == StRun) || (state_q == StDrain);
    assign start_rise = i_start & ~start_q;
    assign net_en     = {NODES{busy}};
    assign dlv        = i_net_data_val & net_en;
    assign acc        = val_q & i_net_en;
    assign xfer       = acc;

    // Node 0 occupies the MSBs of the flattened network vectors.
    for (genvar g = 0; g < NODES; g++) begin : g_node
        assign in_data[g] = i_net_data[(NODES-1-g)*DATA_W +: DATA_W];
        assign o_net_data[(NODES-1-g)*DATA_W +: DATA_W] = data_q[g];
        assign rate_nxt[g]  = rate_step(rate_lfsr_q[g]);
        assign data_nxt[g]  = data_step(data_lfsr_q[g]);
        assign fold_term[g] = dlv[g] ? rotl(in_data[g], g % DATA_W) : '0;
    end

    always_comb begin
        fold = '0;
        for (int unsigned k = 0; k < NODES; k++) fold = fold ^ fold_term[k];
    end

    always_comb begin
        state_d    = state_q;
        rate_cfg_d = rate_cfg_q;
        budget_d   = budget_q;
        tx_d       = tx_q + popcnt(acc);
        rx_d       = rx_q + popcnt(dlv);
        sig_d      = busy ? (rotl(sig_q, 1) ^ fold) : sig_q;
        timeout_d  = timeout_q;
        drain_d    = drain_q;
        val_d      = val_q;
        all_sent   = 1'b1;
        for (int unsigned k = 0; k < NODES; k++) begin
            rate_lfsr_d[k] = rate_lfsr_q[k];
            data_lfsr_d[k] = data_lfsr_q[k];
            loaded_d[k]    = loaded_q[k];
            data_d[k]      = data_q[k];
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start_rise) begin
                    state_d    = StRun;
                    rate_cfg_d = i_rate;
                    budget_d   = i_num_pkts;
                    tx_d       = '0;
                    rx_d       = '0;
                    sig_d      = '0;
                    timeout_d  = 1'b0;
                    val_d      = '0;
                    // Reseeding per run makes a repeated run reproduce its signature.
                    for (int unsigned k = 0; k < NODES; k++) begin
                        rate_lfsr_d[k] = rate_seed(k);
                        data_lfsr_d[k] = data_seed(k);
                        loaded_d[k]    = '0;
                    end
                end
            end
            StRun: begin
                for (int unsigned k = 0; k < NODES; k++) begin
                    if (val_q[k] || (loaded_q[k] != budget_q)) all_sent = 1'b0;
                    if (xfer[k]) val_d[k] = 1'b0;
                    if ((!val_q[k] || xfer[k]) && (loaded_q[k] < budget_q)) begin
                        rate_lfsr_d[k] = rate_nxt[k];
                        if (rate_nxt[k] <= rate_cfg_q) begin
                            data_lfsr_d[k] = data_nxt[k];
                            data_d[k]      = DATA_W'(data_nxt[k]);
                            val_d[k]       = 1'b1;
                            loaded_d[k]    = loaded_q[k] + CNT_W'(1);
                        end
                    end
                end
                if (all_sent) begin
                    state_d = StDrain;
                    drain_d = '0;
                end
            end
            StDrain: begin
                if (rx_q == tx_q) begin
                    state_d = StDone;
                end else if (drain_q == DCW'(DRAIN_TIMEOUT - 1)) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                end else begin
                    drain_d = drain_q + DCW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            start_q    <= 1'b0;
            rate_cfg_q <= '0;
            budget_q   <= '0;
            val_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            sig_q      <= '0;
            timeout_q  <= 1'b0;
            drain_q    <= '0;
            for (int unsigned k = 0; k < NODES; k++) begin
                rate_lfsr_q[k] <= rate_seed(k);
                data_lfsr_q[k] <= data_seed(k);
                loaded_q[k]    <= '0;
                data_q[k]      <= '0;
            end
        end else begin
            state_q    <= state_d;
            start_q    <= i_start;
            rate_cfg_q <= rate_cfg_d;
            budget_q   <= budget_d;
            val_q      <= val_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            sig_q      <= sig_d;
            timeout_q  <= timeout_d;
            drain_q    <= drain_d;
            for (int unsigned k = 0; k < NODES; k++) begin
                rate_lfsr_q[k] <= rate_lfsr_d[k];
                data_lfsr_q[k] <= data_lfsr_d[k];
                loaded_q[k]    <= loaded_d[k];
                data_q[k]      <= data_d[k];
            end
        end
    end

    assign o_busy         = busy;
    assign o_done         = (state_q == StDone);
    assign o_timeout      = timeout_q;
    assign o_tx_count     = tx_q;
    assign o_rx_count     = rx_q;
    assign o_signature    = sig_q;
    assign o_net_data_val = val_q;
    assign o_net_en       = net_en;

endmodule

// File: tb/tb_enoc_traffic_harness.sv
// Randomised bench for enoc_traffic_harness: a cycle-level behavioural model of the traffic rules
// plus a stand-in network (loopback, lossy loopback, fixed-latency shuffle) checked every cycle.

module tb_enoc_traffic_harness;

    localparam int unsigned NODES  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DT     = 64;
    localparam int unsigned TW     = CNT_W + 2;
    localparam logic [31:0] SEED   = 32'hACE1_0001;
    localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    start = 1'b0;
    logic [7:0]              rate = 8'd0;
    logic [CNT_W-1:0]        num_pkts = '0;
    logic                    busy, done, tout;
    logic [TW-1:0]           txc, rxc;
    logic [DATA_W-1:0]       sig;
    logic [NODES*DATA_W-1:0] net_data_o;
    logic [NODES*DATA_W-1:0] net_data_i = '0;
    logic [NODES-1:0]        val_o, en_o;
    logic [NODES-1:0]        en_i = '0;
    logic [NODES-1:0]        val_i = '0;

    enoc_traffic_harness #(
        .NODES(NODES), .DATA_W(DATA_W), .LFSR_SEED(SEED), .CNT_W(CNT_W), .DRAIN_TIMEOUT(DT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .i_start(start), .i_rate(rate), .i_num_pkts(num_pkts),
        .o_busy(busy), .o_done(done), .o_timeout(tout), .o_tx_count(txc), .o_rx_count(rxc),
        .o_signature(sig), .o_net_data(net_data_o), .o_net_data_val(val_o), .i_net_en(en_i),
        .i_net_data(net_data_i), .i_net_data_val(val_i), .o_net_en(en_o)
    );

    always #5 clk = ~clk;

    int          n_pass = 0, n_total = 0;
    int unsigned cyc = 0;
    logic        nx_reset_n = 1'b0, nx_start = 1'b0;
    int          en_mode = 0;   // 0 always ready, 1 ready one cycle in three, 2 random
    int          net_mode = 0;  // 0 loopback, 1 loopback dropping node 2, 2 shuffle with latency

    int               m_phase;
    logic             m_prev_start;
    logic [7:0]       m_rate;
    logic [CNT_W-1:0] m_budget;
    logic [7:0]       m_rl [NODES];
    logic [31:0]      m_dl [NODES];
    int               m_loaded [NODES];
    logic [NODES-1:0] m_val;
    logic [DATA_W-1:0] m_data [NODES];
    int               m_tx, m_rx, m_drain;
    logic [DATA_W-1:0] m_sig;
    logic             m_to;

    typedef struct { int dst; int unsigned t; logic [DATA_W-1:0] d; } pkt_t;
    pkt_t mq[$];

    function automatic logic [7:0] rate_step(input logic [7:0] r);
        return r[0] ? ((r >> 1) ^ 8'hB8) : (r >> 1);
    endfunction

    function automatic logic [31:0] data_step(input logic [31:0] r);
        return r[0] ? ((r >> 1) ^ 32'h8020_0003) : (r >> 1);
    endfunction

    function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x, input int s);
        if (s == 0) return x;
        return (x << s) | (x >> (DATA_W - s));
    endfunction

    function automatic logic [DATA_W-1:0] slice(input logic [NODES*DATA_W-1:0] v, input int k);
        return v[(NODES-1-k)*DATA_W +: DATA_W];
    endfunction

    function automatic logic m_busy();
        return (m_phase == P_RUN) || (m_phase == P_DRAIN);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic reseed();
        for (int k = 0; k < NODES; k++) begin
            m_dl[k] = ((SEED ^ 32'(k)) == 32'd0) ? 32'd1 : (SEED ^ 32'(k));
            m_rl[k] = 8'((k % 255) + 1);
            m_loaded[k] = 0;
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_prev_start = 1'b0; m_rate = 8'd0; m_budget = '0;
        reseed();
        for (int k = 0; k < NODES; k++) m_data[k] = '0;
        m_val = '0; m_tx = 0; m_rx = 0; m_drain = 0; m_sig = '0; m_to = 1'b0;
    endtask

    task automatic model_step();
        logic rise, all_sent, xf;
        logic [DATA_W-1:0] fold;
        int old_tx, old_rx;
        rise = start && !m_prev_start;
        m_prev_start = start;
        old_tx = m_tx; old_rx = m_rx;
        fold = '0;
        for (int k = 0; k < NODES; k++) begin
            if (m_val[k] && en_i[k]) m_tx++;
            if (val_i[k] && m_busy()) begin
                m_rx++;
                fold ^= rotl(slice(net_data_i, k), k % DATA_W);
            end
        end
        if (m_busy()) m_sig = rotl(m_sig, 1) ^ fold;
        case (m_phase)
            P_IDLE, P_DONE: if (rise) begin
                m_phase = P_RUN; m_tx = 0; m_rx = 0; m_sig = '0; m_to = 1'b0;
                m_rate = rate; m_budget = num_pkts; m_val = '0;
                reseed();
            end
            P_RUN: begin
                all_sent = 1'b1;
                for (int k = 0; k < NODES; k++)
                    if (m_val[k] || m_loaded[k] != int'(m_budget)) all_sent = 1'b0;
                for (int k = 0; k < NODES; k++) begin
                    xf = m_val[k] && en_i[k];
                    if ((!m_val[k] || xf) && m_loaded[k] < int'(m_budget)) begin
                        m_rl[k] = rate_step(m_rl[k]);
                        if (m_rl[k] <= m_rate) begin
                            m_dl[k] = data_step(m_dl[k]);
                            m_data[k] = m_dl[k];
                            m_val[k] = 1'b1;
                            m_loaded[k]++;
                        end else m_val[k] = 1'b0;
                    end else if (xf) m_val[k] = 1'b0;
                end
                if (all_sent) begin m_phase = P_DRAIN; m_drain = 0; end
            end
            P_DRAIN: begin
                if (old_rx == old_tx) m_phase = P_DONE;
                else if (m_drain == DT - 1) begin m_phase = P_DONE; m_to = 1'b1; end
                else m_drain++;
            end
            default: ;
        endcase
    endtask

    task automatic compare();
        chk("busy", busy, m_busy());
        chk("done", done, m_phase == P_DONE);
        chk("timeout", tout, m_to);
        chk("tx_count", txc, m_tx);
        chk("rx_count", rxc, m_rx);
        chk("signature", sig, m_sig);
        chk("net_en", en_o, m_busy() ? {NODES{1'b1}} : {NODES{1'b0}});
        chk("net_val", val_o, m_val);
        for (int k = 0; k < NODES; k++)
            if (m_val[k]) chk($sformatf("net_data%0d", k), slice(net_data_o, k), m_data[k]);
    endtask

    task automatic drive_net();
        pkt_t p;
        int idx;
        case (en_mode)
            0: en_i = '1;
            1: en_i = (cyc % 3 == 0) ? '1 : '0;
            default: en_i = NODES'($urandom);
        endcase
        if (net_mode < 2) begin
            val_i = val_o & en_i;
            if (net_mode == 1) val_i[2] = 1'b0;
            net_data_i = net_data_o;
        end else begin
            val_i = '0;
            net_data_i = '0;
            for (int k = 0; k < NODES; k++) begin
                idx = -1;
                for (int i = 0; i < mq.size(); i++)
                    if (idx < 0 && mq[i].dst == k && mq[i].t <= cyc) idx = i;
                if (idx >= 0) begin
                    val_i[k] = 1'b1;
                    net_data_i[(NODES-1-k)*DATA_W +: DATA_W] = mq[idx].d;
                    if (m_busy()) mq.delete(idx);
                end
            end
            for (int k = 0; k < NODES; k++)
                if (val_o[k] && en_i[k]) begin
                    p.dst = (k + 1) % NODES;
                    p.t = cyc + 2 + k;
                    p.d = slice(net_data_o, k);
                    mq.push_back(p);
                end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        compare();
        reset_n = nx_reset_n;
        start = nx_start;
        drive_net();
        if (!reset_n) begin model_reset(); mq.delete(); end
        else model_step();
        cyc++;
    endtask

    task automatic launch(input logic [7:0] r, input int n);
        rate = r;
        num_pkts = CNT_W'(n);
        nx_start = 1'b1; cycle(); cycle();
        nx_start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (!done && n < limit) begin cycle(); n++; end
        chk("done_reached", done, 1'b1);
    endtask

    logic [DATA_W-1:0] ref_sig;
    int                rp;

    initial begin
        model_reset();
        nx_reset_n = 1'b0; repeat (3) cycle();
        chk("rst_busy", busy, 1'b0);
        chk("rst_net_en", en_o, 4'h0);
        chk("rst_tx", txc, 0);
        chk("rst_data", net_data_o, 0);
        nx_reset_n = 1'b1; repeat (2) cycle();

        // Loopback, always ready: first packet of node 0 is one LFSR step past its seed.
        en_mode = 0; net_mode = 0;
        launch(8'd255, 8); cycle();
        chk("first_val", val_o, 4'hF);
        chk("first_data0", slice(net_data_o, 0), 32'hD650_8003);
        wait_done(300);
        chk("lb_tx", txc, 32); chk("lb_rx", rxc, 32); chk("lb_timeout", tout, 1'b0);

        // Loopback with sparse ready: data must hold while stalled.
        en_mode = 1;
        launch(8'd255, 8); wait_done(400);
        chk("stall_tx", txc, 32); chk("stall_rx", rxc, 32);

        // Zero budget: straight through drain.
        en_mode = 0;
        rate = 8'd255; num_pkts = '0;
        nx_start = 1'b1; cycle(); nx_start = 1'b0;
        repeat (3) cycle();
        chk("zero_done", done, 1'b1); chk("zero_tx", txc, 0);
        chk("zero_rx", rxc, 0); chk("zero_sig", sig, 0);

        // Node 2 deliveries lost: drain must time out.
        net_mode = 1;
        launch(8'd255, 8); wait_done(400);
        chk("drop_timeout", tout, 1'b1); chk("drop_rx", rxc, 24); chk("drop_tx", txc, 32);

        // Shuffle network with latency; a rerun must reproduce the signature.
        net_mode = 2;
        launch(8'd64, 100); wait_done(4000);
        chk("mesh_tx", txc, 400); chk("mesh_rx", rxc, 400); chk("mesh_timeout", tout, 1'b0);
        ref_sig = m_sig;
        launch(8'd64, 100); wait_done(4000);
        chk("restart_sig", sig, ref_sig); chk("restart_rx", rxc, 400);

        for (int it = 0; it < 3; it++) begin
            en_mode = 2;
            net_mode = (it == 1) ? 0 : 2;
            rp = $urandom_range(1, 20);
            launch(8'($urandom_range(32, 255)), rp); wait_done(3000);
            chk("rand_tx", txc, NODES * rp); chk("rand_rx", rxc, NODES * rp);
        end

        // Abort mid-run.
        en_mode = 2; net_mode = 2;
        launch(8'd200, 50); repeat (10) cycle();
        nx_reset_n = 1'b0; cycle(); cycle();
        chk("abort_busy", busy, 1'b0); chk("abort_net_en", en_o, 4'h0);
        chk("abort_val", val_o, 4'h0); chk("abort_tx", txc, 0); chk("abort_sig", sig, 0);
        nx_reset_n = 1'b1; cycle();
        en_mode = 0; net_mode = 0;
        launch(8'd255, 3); wait_done(300);
        chk("recover_tx", txc, 12); chk("recover_rx", rxc, 12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
